// File: rtl/lfsr_health_mon.sv
// Statistical health monitor for a 128-bit LFSR stream: counts ones over a window
// of 2^WIN_LOG2 accepted words and flags all-zero, repeated and biased output.
module lfsr_health_mon #(
    parameter int WIN_LOG2 = 8,
    parameter int TOL      = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enable,
    input  logic                  load_seed,
    input  logic [127:0]          lfsr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [WIN_LOG2+7:0]   ones_sum,
    output logic [WIN_LOG2:0]     word_cnt,
    output logic                  alarm_zero,
    output logic                  alarm_stuck,
    output logic                  alarm_bias
);

    localparam int SW = WIN_LOG2 + 8;
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [SW-1:0] EXPECTED = SW'(64 << WIN_LOG2);
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << WIN_LOG2) - 1);
    localparam logic [31:0]   TOL_U    = 32'(TOL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic [SW-1:0]  ones_sum_q;
    logic [CW-1:0]  word_cnt_q;
    logic           alarm_zero_q;
    logic           alarm_stuck_q;
    logic           alarm_bias_q;
    logic [127:0]   prev_word_q;
    logic           prev_valid_q;

    logic [SW-1:0]  ones_sum_d;
    logic [CW-1:0]  word_cnt_d;
    logic [SW-1:0]  diff;
    logic [31:0]    diff_wide;
    logic           bias;
    logic           is_zero;
    logic           is_stuck;

    assign ones_sum_d = ones_sum_q + SW'($countones(lfsr_out));
    assign word_cnt_d = word_cnt_q + CW'(1);
    assign is_zero    = (lfsr_out == 128'd0);
    assign is_stuck   = prev_valid_q && (lfsr_out == prev_word_q);

    // Subtract the smaller from the larger so the distance never wraps.
    assign diff      = (ones_sum_q >= EXPECTED) ? (ones_sum_q - EXPECTED) : (EXPECTED - ones_sum_q);
    assign diff_wide = 32'(diff);
    assign bias      = (diff_wide > TOL_U);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            ones_sum_q    <= '0;
            word_cnt_q    <= '0;
            alarm_zero_q  <= 1'b0;
            alarm_stuck_q <= 1'b0;
            alarm_bias_q  <= 1'b0;
            prev_word_q   <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        ones_sum_q    <= '0;
                        word_cnt_q    <= '0;
                        alarm_zero_q  <= 1'b0;
                        alarm_stuck_q <= 1'b0;
                        alarm_bias_q  <= 1'b0;
                        prev_valid_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // A reseed mid-window invalidates the statistics, so abort
                    // but leave the partial counts visible for debug.
                    if (load_seed) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (enable) begin
                        ones_sum_q   <= ones_sum_d;
                        word_cnt_q   <= word_cnt_d;
                        prev_word_q  <= lfsr_out;
                        prev_valid_q <= 1'b1;
                        if (is_zero)
                            alarm_zero_q <= 1'b1;
                        if (is_stuck)
                            alarm_stuck_q <= 1'b1;
                        if (word_cnt_q == LAST_CNT)
                            state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q      <= DONE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    alarm_bias_q <= bias;
                    pass_q       <= !(alarm_zero_q || alarm_stuck_q || bias);
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign ones_sum    = ones_sum_q;
    assign word_cnt    = word_cnt_q;
    assign alarm_zero  = alarm_zero_q;
    assign alarm_stuck = alarm_stuck_q;
    assign alarm_bias  = alarm_bias_q;

endmodule

// File: tb/tb_lfsr_health_mon.sv
// Directed bench for lfsr_health_mon with a 4-word window (WIN_LOG2=2, TOL=16):
// table of complete windows plus hand-written reset, abort and ignore sequences.
module tb_lfsr_health_mon;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           enable;
    logic           load_seed;
    logic [127:0]   lfsr_out;
    logic           busy;
    logic           done;
    logic           pass;
    logic [9:0]     ones_sum;
    logic [2:0]     word_cnt;
    logic           alarm_zero;
    logic           alarm_stuck;
    logic           alarm_bias;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0][127:0] w;
        int                sum;
        logic              zero;
        logic              stuck;
        logic              bias;
        logic              pass;
    } vec_t;

    vec_t tbl[5];

    localparam logic [127:0] W_AA = {16{8'hAA}};
    localparam logic [127:0] W_55 = {16{8'h55}};
    localparam logic [127:0] W_FF = {16{8'hFF}};
    localparam logic [127:0] W_FE = {{15{8'hFF}}, 8'hFE};
    localparam logic [127:0] W_00 = 128'd0;

    lfsr_health_mon #(.WIN_LOG2(2), .TOL(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .enable      (enable),
        .load_seed   (load_seed),
        .lfsr_out    (lfsr_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .ones_sum    (ones_sum),
        .word_cnt    (word_cnt),
        .alarm_zero  (alarm_zero),
        .alarm_stuck (alarm_stuck),
        .alarm_bias  (alarm_bias)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " pass"}, 32'(pass), 32'd0);
        checkOutput({tag, " ones_sum"}, 32'(ones_sum), 32'd0);
        checkOutput({tag, " word_cnt"}, 32'(word_cnt), 32'd0);
        checkOutput({tag, " alarms"}, 32'({alarm_zero, alarm_stuck, alarm_bias}), 32'd0);
    endtask

    // Runs one full window from IDLE/DONE and checks the CHECK and DONE cycles.
    task automatic applyStimulus(input vec_t v, input string tag);
        start = 1'b1;
        tick();
        checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
        checkOutput({tag, " cleared word_cnt"}, 32'(word_cnt), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable   = 1'b1;
            lfsr_out = v.w[i];
            tick();
        end
        enable = 1'b0;
        checkOutput({tag, " busy in CHECK"}, 32'(busy), 32'd1);
        checkOutput({tag, " done in CHECK"}, 32'(done), 32'd0);
        checkOutput({tag, " word_cnt"}, 32'(word_cnt), 32'd4);
        checkOutput({tag, " ones_sum"}, 32'(ones_sum), 32'(v.sum));
        checkOutput({tag, " alarm_zero"}, 32'(alarm_zero), 32'(v.zero));
        checkOutput({tag, " alarm_stuck"}, 32'(alarm_stuck), 32'(v.stuck));
        tick();
        checkOutput({tag, " done pulse"}, 32'(done), 32'd1);
        checkOutput({tag, " busy in DONE"}, 32'(busy), 32'd0);
        checkOutput({tag, " alarm_bias"}, 32'(alarm_bias), 32'(v.bias));
        checkOutput({tag, " pass"}, 32'(pass), 32'(v.pass));
        tick();
        checkOutput({tag, " done drops"}, 32'(done), 32'd0);
        checkOutput({tag, " pass held"}, 32'(pass), 32'(v.pass));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0].w = {W_55, W_AA, W_55, W_AA}; tbl[0].sum = 256;
        tbl[0].zero = 0; tbl[0].stuck = 0; tbl[0].bias = 0; tbl[0].pass = 1;
        tbl[1].w = {W_AA, W_55, W_AA, W_55}; tbl[1].sum = 256;
        tbl[1].zero = 0; tbl[1].stuck = 0; tbl[1].bias = 0; tbl[1].pass = 1;
        tbl[2].w = {W_FE, W_FF, W_FE, W_FF}; tbl[2].sum = 510;
        tbl[2].zero = 0; tbl[2].stuck = 0; tbl[2].bias = 1; tbl[2].pass = 0;
        tbl[3].w = {W_55, W_00, W_AA, W_AA}; tbl[3].sum = 192;
        tbl[3].zero = 1; tbl[3].stuck = 1; tbl[3].bias = 1; tbl[3].pass = 0;
        tbl[4].w = {W_AA, W_55, W_AA, W_55}; tbl[4].sum = 256;
        tbl[4].zero = 0; tbl[4].stuck = 0; tbl[4].bias = 0; tbl[4].pass = 1;

        reset     = 1'b0;
        start     = 1'b0;
        enable    = 1'b0;
        load_seed = 1'b0;
        lfsr_out  = '0;
        #1;
        checkIdleZero("reset");
        #11;
        reset = 1'b1;

        for (int k = 0; k < 5; k++)
            applyStimulus(tbl[k], $sformatf("win%0d", k));

        // Asynchronous reset in the middle of a window.
        start = 1'b1;
        tick();
        start    = 1'b0;
        enable   = 1'b1;
        lfsr_out = W_AA;
        tick();
        checkOutput("midrun word_cnt", 32'(word_cnt), 32'd1);
        enable = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkIdleZero("async reset");
        #2;
        reset = 1'b1;
        tick();
        checkOutput("no done after reset", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        checkOutput("busy after restart", 32'(busy), 32'd1);
        start = 1'b0;

        // Reseed abort after two words, with start also high.
        enable   = 1'b1;
        lfsr_out = W_AA;
        tick();
        lfsr_out = W_FF;
        tick();
        lfsr_out  = W_55;
        load_seed = 1'b1;
        start     = 1'b1;
        tick();
        load_seed = 1'b0;
        start     = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort pass", 32'(pass), 32'd0);
        checkOutput("abort word_cnt", 32'(word_cnt), 32'd2);
        checkOutput("abort ones_sum", 32'(ones_sum), 32'd192);
        for (int i = 0; i < 3; i++) begin
            enable = (i % 2 == 0);
            tick();
        end
        checkOutput("idle word_cnt held", 32'(word_cnt), 32'd2);
        checkOutput("idle ones_sum held", 32'(ones_sum), 32'd192);
        checkOutput("idle busy", 32'(busy), 32'd0);

        // Gaps in enable and start pulses inside RUN and CHECK are ignored.
        start  = 1'b1;
        enable = 1'b0;
        tick();
        start    = 1'b0;
        enable   = 1'b1;
        lfsr_out = W_AA;
        tick();
        enable = 1'b0;
        tick();
        checkOutput("gap word_cnt", 32'(word_cnt), 32'd1);
        enable   = 1'b1;
        start    = 1'b1;
        lfsr_out = W_55;
        tick();
        checkOutput("start in RUN word_cnt", 32'(word_cnt), 32'd2);
        start    = 1'b0;
        lfsr_out = W_AA;
        tick();
        lfsr_out = W_55;
        tick();
        checkOutput("late CHECK busy", 32'(busy), 32'd1);
        checkOutput("late word_cnt", 32'(word_cnt), 32'd4);
        checkOutput("late ones_sum", 32'(ones_sum), 32'd256);
        enable = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start in CHECK done", 32'(done), 32'd1);
        checkOutput("start in CHECK busy", 32'(busy), 32'd0);
        checkOutput("late pass", 32'(pass), 32'd1);
        tick();
        checkOutput("late done drops", 32'(done), 32'd0);
        checkOutput("late word_cnt held", 32'(word_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
